usb_fs_tx: RTL and testbench

//  Full-speed USB packet transmitter: the transmit end facing the usbdev receiver path.

---
 rtl/usb_pkg.sv | 8 +
 rtl/usb_nrzi_stuffer.sv | 29 ++
 rtl/usb_fs_tx.sv | 129 ++++++++++++
 tb/tb_usb_fs_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: line-state encodings, framing constants and tx FSM states shared by the USB FS tx path.
package usb_pkg;
  typedef enum logic [1:0] {LS_SE0 = 2'b00, LS_K = 2'b01, LS_J = 2'b10} line_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;
  localparam int EOP_SE0_BITS = 2;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_STUFF, S_EOP_SE0, S_EOP_J} tx_state_t;
endpackage

// File: rtl/usb_nrzi_stuffer.sv
// usb_nrzi_stuffer: per-bit NRZI encoder with consecutive-ones counter and stuff request.
module usb_nrzi_stuffer import usb_pkg::*; (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear_i,
  input  logic  bit_strobe_i,
  input  logic  data_bit_i,
  output line_t line_o,
  output logic  stuff_now_o
);
  line_t ref_q;
  logic [2:0] ones_q;
  logic toggle;
  // line_o is the encoding of the bit being strobed; a pending stuff forces a toggle
  assign stuff_now_o = ones_q == STUFF_LIMIT;
  assign toggle = stuff_now_o || !data_bit_i;
  assign line_o = toggle ? (ref_q == LS_J ? LS_K : LS_J) : ref_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ref_q <= LS_J;
      ones_q <= '0;
    end else if (clear_i) begin
      ref_q <= LS_J;
      ones_q <= '0;
    end else if (bit_strobe_i) begin
      ref_q <= line_o;
      ones_q <= toggle ? '0 : ones_q + 3'd1;
    end
endmodule

// File: rtl/usb_fs_tx.sv
// usb_fs_tx: full-speed USB packet transmitter (SYNC + payload + EOP, NRZI, bit stuffing).
module usb_fs_tx import usb_pkg::*; #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       usb_dp,
  output logic       usb_dm,
  output logic       usb_oe,
  output logic       busy,
  output logic       underrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, nxt_q, nxt_d;
  logic last_q, last_d, bdone_q, bdone_d, oe_q, oe_d;
  line_t pad_q, pad_d, line;
  logic strobe, dbit, clear, stuff_now, cnt_last, byte_end;
  usb_nrzi_stuffer u_nrzi (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .bit_strobe_i(strobe),
    .data_bit_i(dbit), .line_o(line), .stuff_now_o(stuff_now)
  );
  // Load point: last clk of a byte's final bit, or of the stuff bit that trails it
  assign cnt_last = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign byte_end = cnt_last && ((state_q == S_DATA && idx_q == 3'd7 && !stuff_now) ||
                                 (state_q == S_STUFF && bdone_q));
  assign clear = state_q inside {S_EOP_SE0, S_EOP_J};
  assign in_ready = state_q == S_IDLE || (byte_end && !last_q);
  assign underrun = byte_end && !last_q && !in_valid;
  assign usb_dp = pad_q[1];
  assign usb_dm = pad_q[0];
  assign usb_oe = oe_q;
  assign busy = oe_q;
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == S_IDLE || cnt_last) ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    sh_d = sh_q;
    nxt_d = nxt_q;
    last_d = last_q;
    bdone_d = bdone_q;
    oe_d = oe_q;
    pad_d = pad_q;
    strobe = 1'b0;
    dbit = sh_q[idx_q + 3'd1];
    if (state_q == S_IDLE) begin
      if (in_valid) begin
        state_d = S_SYNC;
        sh_d = SYNC_BYTE;
        nxt_d = in_data;
        last_d = in_last;
        idx_d = '0;
        oe_d = 1'b1;
        strobe = 1'b1;
        dbit = SYNC_BYTE[0];
        pad_d = line;
      end
    end else if (cnt_last) begin
      if (byte_end) begin
        bdone_d = 1'b0;
        idx_d = '0;
        if (last_q || !in_valid) begin
          state_d = S_EOP_SE0;
          pad_d = LS_SE0;
        end else begin
          state_d = S_DATA;
          sh_d = in_data;
          last_d = in_last;
          strobe = 1'b1;
          dbit = in_data[0];
          pad_d = line;
        end
      end else if (state_q == S_SYNC && idx_q == 3'd7) begin
        state_d = S_DATA;
        sh_d = nxt_q;
        idx_d = '0;
        strobe = 1'b1;
        dbit = nxt_q[0];
        pad_d = line;
      end else if (state_q == S_DATA && stuff_now) begin
        state_d = S_STUFF;
        bdone_d = idx_q == 3'd7;
        strobe = 1'b1;
        pad_d = line;
      end else if (state_q inside {S_SYNC, S_DATA, S_STUFF}) begin
        state_d = state_q == S_STUFF ? S_DATA : state_q;
        idx_d = idx_q + 3'd1;
        strobe = 1'b1;
        pad_d = line;
      end else if (state_q == S_EOP_SE0) begin
        state_d = idx_q == 3'(EOP_SE0_BITS - 1) ? S_EOP_J : S_EOP_SE0;
        idx_d = idx_q == 3'(EOP_SE0_BITS - 1) ? 3'd0 : idx_q + 3'd1;
        pad_d = idx_q == 3'(EOP_SE0_BITS - 1) ? LS_J : LS_SE0;
      end else begin
        state_d = S_IDLE;
        oe_d = 1'b0;
        pad_d = LS_J;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      nxt_q <= '0;
      last_q <= 1'b0;
      bdone_q <= 1'b0;
      oe_q <= 1'b0;
      pad_q <= LS_J;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      nxt_q <= nxt_d;
      last_q <= last_d;
      bdone_q <= bdone_d;
      oe_q <= oe_d;
      pad_q <= pad_d;
    end
endmodule

// File: tb/tb_usb_fs_tx.sv
// tb_usb_fs_tx: scoreboard bench; expected line symbols are queued per packet and popped per bit time.
module tb_usb_fs_tx;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0, in_last = 1'b0, sel = 1'b0, ign = 1'b0;
  logic va, vb, rdy_a, rdy_b, dp_a, dm_a, oe_a, busy_a, und_a, dp_b, dm_b, oe_b, busy_b, und_b;
  int n_tests = 0, n_fail = 0, und_cnt = 0, und_pos = -1, cyc = 0;
  int pos[2];
  byte expq[$];
  int lenq[$];
  int acc[$];
  logic [7:0] pkt[4];
  always #5 clk = ~clk;
  assign va = in_valid && !sel;
  assign vb = in_valid && sel;
  usb_fs_tx #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(va), .in_last(in_last),
    .in_ready(rdy_a), .usb_dp(dp_a), .usb_dm(dm_a), .usb_oe(oe_a), .busy(busy_a), .underrun(und_a)
  );
  usb_fs_tx #(.CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(vb), .in_last(in_last),
    .in_ready(rdy_b), .usb_dp(dp_b), .usb_dm(dm_b), .usb_oe(oe_b), .busy(busy_b), .underrun(und_b)
  );
  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask
  task automatic expect_line(input string s);
    int n = 0;
    for (int i = 0; i < s.len(); i++)
      if (s[i] != " ") begin
        expq.push_back(s[i]);
        n++;
      end
    lenq.push_back(n);
  endtask
  task automatic mon(input int k, input logic oe, input logic dp, input logic dm,
                     input logic bsy, input logic und, input int cpb);
    byte sym, want;
    if (und) begin
      und_cnt++;
      und_pos = pos[k];
    end
    if (oe) begin
      if (pos[k] % cpb == 0) begin
        sym = (dp && !dm) ? "J" : (!dp && dm) ? "K" : (!dp && !dm) ? "0" : "X";
        want = "-";
        if (expq.size() > 0) want = expq.pop_front();
        n_tests++;
        if (sym != want) begin
          n_fail++;
          $display("FAIL line dut%0d bit %0d: actual %c, required %c", k, pos[k] / cpb, sym, want);
        end
        check("busy during packet", int'(bsy), 1);
      end
      pos[k]++;
    end else if (pos[k] != 0) begin
      check("oe high clocks", pos[k], lenq.size() > 0 ? lenq.pop_front() * cpb : 0);
      check("busy after EOP", int'(bsy), 0);
      pos[k] = 0;
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!rst_n || ign) begin
      pos[0] = 0;
      pos[1] = 0;
    end else begin
      if (va && rdy_a) acc.push_back(cyc);
      mon(0, oe_a, dp_a, dm_a, busy_a, und_a, 4);
      mon(1, oe_b, dp_b, dm_b, busy_b, und_b, 2);
    end
  end
  task automatic send(input int n, input bit trunc);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data = pkt[i];
      in_last = !trunc && (i == n - 1);
      @(negedge clk);
      while (!(sel ? rdy_b : rdy_a) && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) check("accept timeout", w, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_done();
    int w = 0;
    @(negedge clk);
    while ((sel ? oe_b : oe_a) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("packet end timeout", int'(w < 1000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset oe", int'(oe_a), 0);
    check("reset dp", int'(dp_a), 1);
    check("reset dm", int'(dm_a), 0);
    check("reset in_ready", int'(rdy_a), 1);
    check("reset busy", int'(busy_a), 0);
    check("reset underrun", int'(und_a), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pkt[0] = 8'hD2;
    expect_line("KJKJKJKK JJKJJKKK 00J");
    und_cnt = 0;
    send(1, 1'b0);
    wait_done();
    check("ack underrun count", und_cnt, 0);
    check("idle dp after ack", int'(dp_a), 1);
    check("idle dm after ack", int'(dm_a), 0);
    pkt[0] = 8'hFF;
    expect_line("KJKJKJKK KKKKKJJJJ 00J");
    send(1, 1'b0);
    wait_done();
    pkt[0] = 8'hFC;
    expect_line("KJKJKJKK JKKKKKKKJ 00J");
    send(1, 1'b0);
    wait_done();
    acc.delete();
    pkt[0] = 8'h69;
    pkt[1] = 8'h00;
    pkt[2] = 8'h10;
    expect_line("KJKJKJKK KJKKJJJK JKJKJKJK JKJKKJKJ 00J");
    und_cnt = 0;
    send(3, 1'b0);
    wait_done();
    check("stream accept count", acc.size(), 3);
    check("stream accept spacing", acc.size() >= 3 ? acc[2] - acc[1] : -1, 32);
    check("stream underrun count", und_cnt, 0);
    pkt[0] = 8'hC3;
    expect_line("KJKJKJKK KKJKJKKK 00J");
    und_cnt = 0;
    und_pos = -1;
    send(1, 1'b1);
    wait_done();
    check("underrun pulse count", und_cnt, 1);
    check("underrun position", und_pos, 63);
    ign = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hD2;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    check("pre-reset oe", int'(oe_a), 1);
    rst_n = 1'b0;
    #1;
    check("async reset oe", int'(oe_a), 0);
    check("async reset busy", int'(busy_a), 0);
    check("async reset underrun", int'(und_a), 0);
    check("async reset dp", int'(dp_a), 1);
    check("async reset dm", int'(dm_a), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ign = 1'b0;
    pkt[0] = 8'hD2;
    expect_line("KJKJKJKK JJKJJKKK 00J");
    send(1, 1'b0);
    wait_done();
    sel = 1'b1;
    expect_line("KJKJKJKK JJKJJKKK 00J");
    send(1, 1'b0);
    wait_done();
    sel = 1'b0;
    check("unconsumed expected bits", expq.size(), 0);
    check("unconsumed packet lengths", lenq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
